wb_port_arbiter: RTL



---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_sat_counter.sv | 41 ++++
 rtl/wb_port_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and constants for the writeback-port arbiter.
//                Holds the register address width, the default data width,
//                the arbiter state encoding and the hard-wired zero register.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int RegAddrW     = 5;
    localparam int WB_WORD_SIZE = 32;

    typedef enum logic [0:0] {
        WB_PIPE_PRI = 1'b0,
        WB_LU_FORCE = 1'b1
    } wb_arb_state_e;

    localparam logic [RegAddrW-1:0] WB_ZERO_REG = 5'd0;

endpackage
`default_nettype wire

// File: rtl/wb_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sat_counter
//  Description : Saturating up-counter with synchronous clear. Counts up on
//                i_inc, stops at MAX, and returns to zero on rst or i_clr
//                (clear wins over increment).
//  Ports       : clk     - clock
//                rst     - synchronous active-high reset
//                i_clr   - synchronous clear
//                i_inc   - increment request
//                o_count - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Shares the single register-file write port between the
//                in-order pipeline writeback and an out-of-order long-latency
//                unit (LU). The pipeline has priority; after MaxWait
//                consecutive refusals the LU is force-granted for one cycle
//                and the pipeline is stalled. The write port is registered.
//  Ports       : clk, rst                       - clock, sync active-high reset
//                pipe_valid/pipe_rdn/pipe_rdd   - pipeline writeback request
//                pipe_stall                     - pipeline must hold MEM/WB
//                lu_valid/lu_rdn/lu_rdd         - LU result request
//                lu_ready                       - LU result accepted
//                rf_we/rf_waddr/rf_wdata        - registered write port
//                conflict_cnt/forced_cnt        - statistics counters
//  Config      : WB_ARB_STATS_EN - when defined, conflict_cnt and forced_cnt
//                are live saturating counters; otherwise both read zero and
//                no counter flops exist.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int WordSize = WB_WORD_SIZE,
    parameter int MaxWait  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipe_valid,
    input  logic [RegAddrW-1:0] pipe_rdn,
    input  logic [WordSize-1:0] pipe_rdd,
    output logic                pipe_stall,
    input  logic                lu_valid,
    input  logic [RegAddrW-1:0] lu_rdn,
    input  logic [WordSize-1:0] lu_rdd,
    output logic                lu_ready,
    output logic                rf_we,
    output logic [RegAddrW-1:0] rf_waddr,
    output logic [WordSize-1:0] rf_wdata,
    output logic [15:0]         conflict_cnt,
    output logic [15:0]         forced_cnt
);

    // MaxWait is at most 15, so 4 bits always hold the saturated value.
    localparam int                c_WAIT_W    = 4;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MaxWait - 1);

    wb_arb_state_e       r_state;
    wb_arb_state_e       w_state_nxt;

    logic                w_pipe_want;
    logic                w_lu_want;
    logic                w_grant_lu;
    logic                w_grant_pipe;
    logic                w_stall;
    logic [c_WAIT_W-1:0] w_wait_cnt;

    logic                r_rf_we;
    logic [RegAddrW-1:0] r_rf_waddr;
    logic [WordSize-1:0] r_rf_wdata;

    // Writes to x0 are architecturally discarded, so they never compete.
    assign w_pipe_want = pipe_valid && (pipe_rdn != WB_ZERO_REG);
    assign w_lu_want   = lu_valid   && (lu_rdn   != WB_ZERO_REG);

    always_comb begin
        w_grant_lu  = 1'b0;
        w_stall     = 1'b0;
        w_state_nxt = WB_PIPE_PRI;
        case (r_state)
            WB_PIPE_PRI: begin
                w_grant_lu = w_lu_want && !w_pipe_want;
                if (w_lu_want && w_pipe_want && (w_wait_cnt == c_WAIT_LAST)) begin
                    w_state_nxt = WB_LU_FORCE;
                end
            end
            WB_LU_FORCE: begin
                // Only stall the pipe if the LU actually takes the port;
                // a dropped or x0 LU result leaves the port to the pipe.
                w_grant_lu = w_lu_want;
                w_stall    = w_pipe_want && w_lu_want;
            end
            default: begin
                w_state_nxt = WB_PIPE_PRI;
            end
        endcase
    end

    // Grants are mutually exclusive: a pipe write loses only to an LU grant.
    assign w_grant_pipe = w_pipe_want && !w_grant_lu;

    // Handshakes are masked during reset so nothing is consumed that the
    // cleared write port would then drop.
    assign lu_ready   = !rst && (w_grant_lu || (lu_valid && (lu_rdn == WB_ZERO_REG)));
    assign pipe_stall = !rst && w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WB_PIPE_PRI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (w_grant_lu) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= lu_rdn;
            r_rf_wdata <= lu_rdd;
        end else if (w_grant_pipe) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= pipe_rdn;
            r_rf_wdata <= pipe_rdd;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

    // Consecutive refusals of the currently presented LU result.
    wb_sat_counter #(
        .WIDTH (c_WAIT_W),
        .MAX   (MaxWait)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_grant_lu || !lu_valid),
        .i_inc   (w_lu_want && !w_grant_lu),
        .o_count (w_wait_cnt)
    );

`ifdef WB_ARB_STATS_EN
    wb_sat_counter #(
        .WIDTH (16),
        .MAX   (16'hFFFF)
    ) u_conflict_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_inc   (w_pipe_want && w_lu_want),
        .o_count (conflict_cnt)
    );

    wb_sat_counter #(
        .WIDTH (16),
        .MAX   (16'hFFFF)
    ) u_forced_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_inc   ((r_state == WB_LU_FORCE) && w_grant_lu),
        .o_count (forced_cnt)
    );
`else
    assign conflict_cnt = 16'd0;
    assign forced_cnt   = 16'd0;
`endif

endmodule
`default_nettype wire
